cp0: RTL and testbench

//   Coprocessor-0 for the pipelined MIPS core; sits in the M stage, directly upstream of pc.

---
 rtl/cp0.sv | 111 +++++++++++
 tb/tb_cp0.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/cp0.sv
// Coprocessor-0 for the pipelined MIPS core: SR/Cause/EPC/PRId, interrupt vs exception
// arbitration in the M stage, mfc0 read mux and mtc0 write path.
module cp0 #(
  parameter logic [31:0] PRID_VAL = 32'h4D49_5053,
  parameter logic [5:0]  IM_RESET = 6'b000000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] pc_m,
  input  logic        bd_m,
  input  logic        exc_valid,
  input  logic [4:0]  exc_code,
  input  logic [5:0]  hw_int,
  input  logic [4:0]  addr,
  input  logic        we,
  input  logic [31:0] wdata,
  input  logic        eret,
  output logic [31:0] rdata,
  output logic [31:0] epc,
  output logic        intreq
);

  localparam logic [4:0] ADDR_SR    = 5'd12;
  localparam logic [4:0] ADDR_CAUSE = 5'd13;
  localparam logic [4:0] ADDR_EPC   = 5'd14;
  localparam logic [4:0] ADDR_PRID  = 5'd15;

  logic [5:0]  sr_im_q,     sr_im_d;
  logic        sr_exl_q,    sr_exl_d;
  logic        sr_ie_q,     sr_ie_d;
  logic        cause_bd_q,  cause_bd_d;
  logic [5:0]  cause_ip_q;
  logic [4:0]  cause_exc_q, cause_exc_d;
  logic [31:0] epc_q,       epc_d;

  logic        int_pend;
  logic        exc_pend;
  logic [31:0] pc_aligned;
  logic [31:0] victim_pc;

  // Arbitration is purely combinational so pc can redirect in the same cycle.
  assign int_pend = (|(hw_int & sr_im_q)) & sr_ie_q & ~sr_exl_q;
  assign exc_pend = exc_valid & ~sr_exl_q;
  assign intreq   = int_pend | exc_pend;

  // A delay-slot victim restarts at its branch; wraps modulo 2^32.
  assign pc_aligned = {pc_m[31:2], 2'b00};
  assign victim_pc  = bd_m ? (pc_aligned - 32'd4) : pc_aligned;

  assign epc = epc_q;

  // Next-state: exception entry beats eret, which beats mtc0.
  always_comb begin
    sr_im_d     = sr_im_q;
    sr_exl_d    = sr_exl_q;
    sr_ie_d     = sr_ie_q;
    cause_bd_d  = cause_bd_q;
    cause_exc_d = cause_exc_q;
    epc_d       = epc_q;
    if (intreq) begin
      sr_exl_d    = 1'b1;
      cause_exc_d = int_pend ? 5'd0 : exc_code;
      cause_bd_d  = bd_m;
      epc_d       = victim_pc;
    end else if (eret) begin
      sr_exl_d = 1'b0;
    end else if (we) begin
      case (addr)
        ADDR_SR: begin
          sr_im_d  = wdata[15:10];
          sr_exl_d = wdata[1];
          sr_ie_d  = wdata[0];
        end
        ADDR_EPC: epc_d = wdata;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sr_im_q     <= IM_RESET;
      sr_exl_q    <= 1'b0;
      sr_ie_q     <= 1'b0;
      cause_bd_q  <= 1'b0;
      cause_ip_q  <= 6'd0;
      cause_exc_q <= 5'd0;
      epc_q       <= 32'd0;
    end else begin
      sr_im_q     <= sr_im_d;
      sr_exl_q    <= sr_exl_d;
      sr_ie_q     <= sr_ie_d;
      cause_bd_q  <= cause_bd_d;
      cause_ip_q  <= hw_int;
      cause_exc_q <= cause_exc_d;
      epc_q       <= epc_d;
    end
  end

  always_comb begin
    rdata = 32'd0;
    case (addr)
      ADDR_SR:    rdata = {16'd0, sr_im_q, 8'd0, sr_exl_q, sr_ie_q};
      ADDR_CAUSE: rdata = {cause_bd_q, 15'd0, cause_ip_q, 3'd0, cause_exc_q, 2'd0};
      ADDR_EPC:   rdata = epc_q;
      ADDR_PRID:  rdata = PRID_VAL;
      default:    rdata = 32'd0;
    endcase
  end

endmodule

// File: tb/tb_cp0.sv
// Directed bench for cp0: reset values, interrupt/exception entry, eret, mtc0 rules,
// EPC wrap and asynchronous reset mid-exception.
module tb_cp0;

  logic        clk;
  logic        reset;
  logic [31:0] pc_m;
  logic        bd_m;
  logic        exc_valid;
  logic [4:0]  exc_code;
  logic [5:0]  hw_int;
  logic [4:0]  addr;
  logic        we;
  logic [31:0] wdata;
  logic        eret;
  logic [31:0] rdata;
  logic [31:0] epc;
  logic        intreq;

  int err_cnt = 0;
  int chk_cnt = 0;

  localparam logic [31:0] PRID = 32'h4D49_5053;

  cp0 dut (
    .clk       (clk),
    .reset     (reset),
    .pc_m      (pc_m),
    .bd_m      (bd_m),
    .exc_valid (exc_valid),
    .exc_code  (exc_code),
    .hw_int    (hw_int),
    .addr      (addr),
    .we        (we),
    .wdata     (wdata),
    .eret      (eret),
    .rdata     (rdata),
    .epc       (epc),
    .intreq    (intreq)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    pc_m = 32'd0; bd_m = 1'b0; exc_valid = 1'b0; exc_code = 5'd0;
    we = 1'b0; wdata = 32'd0; eret = 1'b0;
  endtask

  task automatic read_reg(input string tag, input logic [4:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    check(tag, rdata, exp);
  endtask

  task automatic mtc0(input logic [4:0] a, input logic [31:0] d);
    addr = a; we = 1'b1; wdata = d;
    tick();
    we = 1'b0;
  endtask

  initial begin
    idle_inputs();
    hw_int = 6'd0;
    addr   = 5'd0;
    reset  = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;

    // 1: reset state
    read_reg("rst_sr",    5'd12, 32'd0);
    read_reg("rst_cause", 5'd13, 32'd0);
    read_reg("rst_epc",   5'd14, 32'd0);
    read_reg("rst_prid",  5'd15, PRID);
    read_reg("rst_unmap", 5'd3,  32'd0);
    check("rst_epc_out", epc, 32'd0);
    hw_int = 6'h3F;
    #1 check("rst_intreq_masked", intreq, 0);
    hw_int = 6'd0;

    // 2: timer interrupt entry
    mtc0(5'd12, 32'h0000_0401);
    read_reg("sr_written", 5'd12, 32'h0000_0401);
    hw_int = 6'h01; pc_m = 32'h3010;
    #1 check("int_intreq", intreq, 1);
    tick();
    hw_int = 6'd0;
    #1 check("int_intreq_after", intreq, 0);
    check("int_epc", epc, 32'h3010);
    read_reg("int_sr", 5'd12, 32'h0000_0403);
    read_reg("int_cause", 5'd13, 32'h0000_0400);

    // eret, then synchronous exception in delay slot
    eret = 1'b1;
    #1 check("eret1_epc", epc, 32'h3010);
    tick();
    eret = 1'b0;
    read_reg("eret1_sr", 5'd12, 32'h0000_0401);
    exc_valid = 1'b1; exc_code = 5'd12; pc_m = 32'h3024; bd_m = 1'b1;
    #1 check("ov_intreq", intreq, 1);
    tick();
    idle_inputs();
    check("ov_epc", epc, 32'h3020);
    read_reg("ov_cause", 5'd13, 32'h8000_0030);
    read_reg("ov_sr", 5'd12, 32'h0000_0403);

    // 4: EXL masks both sources; eret clears EXL next cycle
    exc_valid = 1'b1; exc_code = 5'd4; hw_int = 6'h01;
    #1 check("exl_masks", intreq, 0);
    exc_valid = 1'b0; hw_int = 6'd0; eret = 1'b1;
    #1 check("eret2_epc", epc, 32'h3020);
    read_reg("eret2_sr_same", 5'd12, 32'h0000_0403);
    tick();
    eret = 1'b0;
    read_reg("eret2_sr_next", 5'd12, 32'h0000_0401);

    // 5: interrupt beats exception; same-cycle mtc0 discarded
    mtc0(5'd12, 32'h0000_1001);
    hw_int = 6'h04; exc_valid = 1'b1; exc_code = 5'd10; pc_m = 32'h3040;
    addr = 5'd14; we = 1'b1; wdata = 32'hDEAD_BEE0;
    #1 check("prio_intreq", intreq, 1);
    tick();
    idle_inputs();
    hw_int = 6'd0;
    check("prio_epc", epc, 32'h3040);
    read_reg("prio_cause", 5'd13, 32'h0000_1000);

    // mtc0 rules: no bypass, Cause/PRId read-only, unmapped ignored
    eret = 1'b1;
    tick();
    eret = 1'b0;
    addr = 5'd14; we = 1'b1; wdata = 32'h1234_5678;
    #1 check("mtc0_no_bypass", epc, 32'h3040);
    tick();
    we = 1'b0;
    check("mtc0_epc", epc, 32'h1234_5678);
    read_reg("cause_before_wr", 5'd13, 32'h0000_0000);
    mtc0(5'd13, 32'hFFFF_FFFF);
    read_reg("cause_ro", 5'd13, 32'h0000_0000);
    mtc0(5'd15, 32'h0);
    read_reg("prid_ro", 5'd15, PRID);
    mtc0(5'd12, 32'hFFFF_FFFE);
    read_reg("sr_fields", 5'd12, 32'h0000_FC02);
    mtc0(5'd12, 32'h0000_0401);

    // IP tracks hw_int every edge
    hw_int = 6'h28;
    tick();
    read_reg("ip_track", 5'd13, 32'h0000_A000);
    hw_int = 6'd0;
    tick();

    // EPC wrap and low-bit alignment
    exc_valid = 1'b1; exc_code = 5'd5; pc_m = 32'h0; bd_m = 1'b1;
    tick();
    idle_inputs();
    check("epc_wrap", epc, 32'hFFFF_FFFC);
    read_reg("wrap_cause", 5'd13, 32'h8000_0014);
    eret = 1'b1;
    tick();
    eret = 1'b0;
    exc_valid = 1'b1; exc_code = 5'd4; pc_m = 32'h3013;
    tick();
    idle_inputs();
    check("epc_align", epc, 32'h3010);
    eret = 1'b1;
    tick();
    eret = 1'b0;

    // 6: async reset mid-exception
    mtc0(5'd12, 32'h0000_1001);
    exc_valid = 1'b1; exc_code = 5'd12; pc_m = 32'h3050;
    tick();
    idle_inputs();
    check("pre_rst_epc", epc, 32'h3050);
    hw_int = 6'h04;
    #2 reset = 1'b1;
    #1;
    check("arst_epc", epc, 32'd0);
    check("arst_intreq", intreq, 0);
    read_reg("arst_sr", 5'd12, 32'd0);
    read_reg("arst_cause", 5'd13, 32'd0);
    tick();
    reset = 1'b0;
    hw_int = 6'd0;

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
